// File: rtl/fetch_pc_ctrl.sv
// fetch_pc_ctrl: program counter and fetch control for the fetch stage.
// Produces the fetch address plus instruction-memory read-enable/flush and
// tracks the (pc, valid) pair matching the word the memory is presenting.
module fetch_pc_ctrl #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_target,
   input  logic        halt_req,
   output logic [31:0] pc,
   output logic        imem_read_en,
   output logic        imem_flush,
   output logic [31:0] if_pc,
   output logic        if_valid,
   output logic        misaligned_fault,
   output logic        halted,
   output logic [31:0] fetch_count
);

   localparam logic [0:0] RUN  = 1'b0;
   localparam logic [0:0] HALT = 1'b1;

   logic [0:0]  state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] ifPc_q, ifPc_d;
   logic        ifValid_q, ifValid_d;
   logic        fault_q, fault_d;
   logic [31:0] fetchCount_q, fetchCount_d;
   logic        targetMisaligned;

   assign targetMisaligned = (redirect_target[1:0] != 2'b00);

   // Next-state selection: redirect beats stall beats advance; HALT only clears if_valid
   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      ifPc_d       = ifPc_q;
      ifValid_d    = ifValid_q;
      fault_d      = fault_q;
      fetchCount_d = fetchCount_q;
      if (state_q == HALT) begin
         ifValid_d = 1'b0;
      end else begin
         if (redirect_valid) begin
            pc_d      = {redirect_target[31:2], 2'b00};
            ifPc_d    = pc_q;
            ifValid_d = 1'b0;
            if (targetMisaligned) begin
               fault_d = 1'b1;
               state_d = HALT;
            end
         end else if (!stall) begin
            pc_d         = pc_q + 32'd4;
            ifPc_d       = pc_q;
            ifValid_d    = 1'b1;
            fetchCount_d = fetchCount_q + 32'd1;
         end
         if (halt_req) begin
            state_d = HALT;
         end
      end
   end

   // State registers with synchronous active-high reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= RUN;
         pc_q         <= RESET_PC;
         ifPc_q       <= 32'd0;
         ifValid_q    <= 1'b0;
         fault_q      <= 1'b0;
         fetchCount_q <= 32'd0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         ifPc_q       <= ifPc_d;
         ifValid_q    <= ifValid_d;
         fault_q      <= fault_d;
         fetchCount_q <= fetchCount_d;
      end
   end

   // Memory controls: read only on a clean advance, flush on redirect or while halted
   always_comb begin
      imem_read_en = !rst && (state_q == RUN) && !stall && !redirect_valid;
      imem_flush   = !rst && ((state_q == HALT) || redirect_valid);
   end

   assign pc               = pc_q;
   assign if_pc            = ifPc_q;
   assign if_valid         = ifValid_q;
   assign misaligned_fault = fault_q;
   assign halted           = (state_q == HALT);
   assign fetch_count      = fetchCount_q;

endmodule

// File: tb/tb_fetch_pc_ctrl.sv
// tb_fetch_pc_ctrl: directed and randomized stimulus against a behavioural
// model; expectations are queued and checked by independent monitors.
module tb_fetch_pc_ctrl;

   localparam logic [31:0] RESET_PC = 32'h0000_0100;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        stall = 1'b0;
   logic        redirectValid = 1'b0;
   logic [31:0] redirectTarget = 32'd0;
   logic        haltReq = 1'b0;
   logic [31:0] pc;
   logic        imemReadEn;
   logic        imemFlush;
   logic [31:0] ifPc;
   logic        ifValid;
   logic        misalignedFault;
   logic        halted;
   logic [31:0] fetchCount;

   typedef struct {
      logic readEn;
      logic flush;
   } combExp_t;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] ifPc;
      logic        ifValid;
      logic        fault;
      logic        halted;
      logic [31:0] count;
   } regExp_t;

   combExp_t combQ[$];
   regExp_t  regQ[$];
   combExp_t ce;
   regExp_t  re;

   int testsRun = 0;
   int testsFailed = 0;

   // Reference model state, described directly in architectural terms
   logic [31:0] mPc;
   logic [31:0] mIfPc;
   logic        mIfValid;
   logic        mFault;
   logic        mHalted;
   logic [31:0] mCount;

   fetch_pc_ctrl #(.RESET_PC(RESET_PC)) dut (
      .clk(clk),
      .rst(rst),
      .stall(stall),
      .redirect_valid(redirectValid),
      .redirect_target(redirectTarget),
      .halt_req(haltReq),
      .pc(pc),
      .imem_read_en(imemReadEn),
      .imem_flush(imemFlush),
      .if_pc(ifPc),
      .if_valid(ifValid),
      .misaligned_fault(misalignedFault),
      .halted(halted),
      .fetch_count(fetchCount)
   );

   // Free-running clock, period 10
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      testsRun++;
      if (actual !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
      end
   endtask

   // Drive one cycle of inputs and queue the model's view of that cycle
   task automatic applyStimulus(input logic r, input logic s, input logic rv,
                                input logic [31:0] tgt, input logic h);
      combExp_t c;
      regExp_t  q;
      @(negedge clk);
      rst = r;
      stall = s;
      redirectValid = rv;
      redirectTarget = tgt;
      haltReq = h;
      if (r) begin
         c.readEn = 1'b0;
         c.flush  = 1'b0;
      end else begin
         c.readEn = !mHalted && !s && !rv;
         c.flush  = mHalted || rv;
      end
      combQ.push_back(c);
      if (r) begin
         mPc = RESET_PC; mIfPc = 0; mIfValid = 0; mFault = 0; mHalted = 0; mCount = 0;
      end else if (mHalted) begin
         mIfValid = 0;
      end else begin
         if (rv) begin
            mIfPc = mPc;
            mPc = tgt & 32'hFFFF_FFFC;
            mIfValid = 0;
            if (tgt % 4 != 0) begin
               mFault = 1;
               mHalted = 1;
            end
         end else if (!s) begin
            mIfPc = mPc;
            mPc = mPc + 32'd4;
            mIfValid = 1;
            mCount = mCount + 32'd1;
         end
         if (h) mHalted = 1;
      end
      q.pc = mPc; q.ifPc = mIfPc; q.ifValid = mIfValid;
      q.fault = mFault; q.halted = mHalted; q.count = mCount;
      regQ.push_back(q);
   endtask

   // Combinational monitor: sampled mid-low-phase after inputs settle
   initial begin
      forever begin
         @(negedge clk);
         #2;
         if (combQ.size() > 0) begin
            ce = combQ.pop_front();
            checkOutput("imem_read_en", {31'd0, imemReadEn}, {31'd0, ce.readEn});
            checkOutput("imem_flush", {31'd0, imemFlush}, {31'd0, ce.flush});
         end
      end
   end

   // Registered monitor: sampled just after the rising edge
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (regQ.size() > 0) begin
            re = regQ.pop_front();
            checkOutput("pc", pc, re.pc);
            checkOutput("if_pc", ifPc, re.ifPc);
            checkOutput("if_valid", {31'd0, ifValid}, {31'd0, re.ifValid});
            checkOutput("misaligned_fault", {31'd0, misalignedFault}, {31'd0, re.fault});
            checkOutput("halted", {31'd0, halted}, {31'd0, re.halted});
            checkOutput("fetch_count", fetchCount, re.count);
         end
      end
   end

   // Safety net so the run always terminates
   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   // Directed scenarios followed by randomized traffic
   initial begin
      logic        rs, st, rv, hq;
      logic [31:0] tg;
      applyStimulus(1, 0, 0, 0, 0);
      applyStimulus(1, 0, 0, 0, 0);
      repeat (3) applyStimulus(0, 0, 0, 0, 0);
      repeat (2) applyStimulus(0, 1, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 0);
      applyStimulus(0, 0, 1, 32'h40, 0);
      repeat (2) applyStimulus(0, 0, 0, 0, 0);
      applyStimulus(0, 1, 1, 32'h40, 0);
      repeat (2) applyStimulus(0, 0, 0, 0, 0);
      applyStimulus(0, 0, 1, 32'h42, 0);
      repeat (2) applyStimulus(0, 0, 0, 0, 0);
      applyStimulus(0, 0, 1, 32'h80, 0);
      applyStimulus(0, 1, 0, 0, 0);
      applyStimulus(1, 0, 0, 0, 0);
      applyStimulus(0, 0, 1, 32'hFFFF_FFFC, 0);
      repeat (2) applyStimulus(0, 0, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 1);
      repeat (3) applyStimulus(0, 0, 0, 0, 0);
      applyStimulus(0, 0, 1, 32'h200, 1);
      applyStimulus(1, 0, 0, 0, 0);
      repeat (2) applyStimulus(0, 0, 0, 0, 0);
      for (int i = 0; i < 400; i++) begin
         rs = ($urandom_range(99) < 3);
         st = ($urandom_range(99) < 25);
         rv = ($urandom_range(99) < 15);
         hq = ($urandom_range(99) < 3);
         tg = $urandom;
         if ($urandom_range(7) != 0) tg = tg & 32'hFFFF_FFFC;
         applyStimulus(rs, st, rv, tg, hq);
      end
      @(negedge clk);
      @(negedge clk);
      #3;
      checkOutput("queue_drain", combQ.size() + regQ.size(), 32'd0);
      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
